// File: rtl/decode_unit.sv
// decode_unit: RV32I-lite ID stage with register file, immediate/control decode,
// load-use hazard detection and ID/EX pipeline registers.
module decode_unit #(
    parameter int bits      = 32,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] IR,
    input  logic [bits-1:0] PC,
    input  logic [bits-1:0] NPC,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [bits-1:0] wb_data,
    output logic            stall,
    output logic [bits-1:0] id_pc,
    output logic [bits-1:0] id_npc,
    output logic [bits-1:0] rs1_data,
    output logic [bits-1:0] rs2_data,
    output logic [bits-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            branch,
    output logic            jump,
    output logic [1:0]      wb_sel,
    output logic            illegal
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [bits-1:0] rf [0:31];
    logic [6:0]      opc;
    logic [4:0]      f_rs1, f_rs2;
    logic [bits-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, c_imm;
    logic [bits-1:0] rd1, rd2;
    logic [3:0]      f3_op, c_alu_op;
    logic            c_src_a, c_src_b, c_mr, c_mw, c_rw, c_br, c_jmp, c_ill;
    logic [1:0]      c_wb_sel;
    logic            use1, use2, bubble;

    assign opc   = IR[6:0];
    assign f_rs1 = IR[19:15];
    assign f_rs2 = IR[24:20];
    assign imm_i = {{(bits-12){IR[31]}}, IR[31:20]};
    assign imm_s = {{(bits-12){IR[31]}}, IR[31:25], IR[11:7]};
    assign imm_b = {{(bits-13){IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
    assign imm_u = {IR[31:12], 12'b0};
    assign imm_j = {{(bits-21){IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};

    // IR[30] selects SUB only for register-register ops; shifts honour it for both forms
    always_comb begin
        case (IR[14:12])
            3'd0:    f3_op = (opc == OP_REG && IR[30]) ? 4'd1 : 4'd0;
            3'd1:    f3_op = 4'd2;
            3'd2:    f3_op = 4'd3;
            3'd3:    f3_op = 4'd4;
            3'd4:    f3_op = 4'd5;
            3'd5:    f3_op = IR[30] ? 4'd7 : 4'd6;
            3'd6:    f3_op = 4'd8;
            default: f3_op = 4'd9;
        endcase
    end

    always_comb begin
        c_alu_op = 4'd0;
        c_src_a  = 1'b0;
        c_src_b  = 1'b0;
        c_mr     = 1'b0;
        c_mw     = 1'b0;
        c_rw     = 1'b0;
        c_br     = 1'b0;
        c_jmp    = 1'b0;
        c_ill    = 1'b0;
        c_wb_sel = 2'b00;
        c_imm    = imm_i;
        case (opc)
            OP_LUI:    begin c_alu_op = 4'd10; c_src_b = 1'b1; c_rw = 1'b1; c_imm = imm_u; end
            OP_AUIPC:  begin c_src_a = 1'b1; c_src_b = 1'b1; c_rw = 1'b1; c_imm = imm_u; end
            OP_JAL:    begin c_jmp = 1'b1; c_src_a = 1'b1; c_src_b = 1'b1; c_rw = 1'b1; c_wb_sel = 2'b10; c_imm = imm_j; end
            OP_JALR:   begin c_jmp = 1'b1; c_src_b = 1'b1; c_rw = 1'b1; c_wb_sel = 2'b10; end
            OP_BRANCH: begin c_br = 1'b1; c_alu_op = 4'd1; c_imm = imm_b; end
            OP_LOAD:   begin c_mr = 1'b1; c_src_b = 1'b1; c_rw = 1'b1; c_wb_sel = 2'b01; end
            OP_STORE:  begin c_mw = 1'b1; c_src_b = 1'b1; c_imm = imm_s; end
            OP_IMM:    begin c_alu_op = f3_op; c_src_b = 1'b1; c_rw = 1'b1; end
            OP_REG:    begin c_alu_op = f3_op; c_rw = 1'b1; end
            default:   c_ill = 1'b1;
        endcase
    end

    assign use1   = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign use2   = opc == OP_REG || opc == OP_BRANCH || opc == OP_STORE;
    assign stall  = !flush && mem_read && rd != 5'd0 &&
                    ((use1 && f_rs1 == rd) || (use2 && f_rs2 == rd));
    assign bubble = flush || stall;

    assign rd1 = f_rs1 == 5'd0 ? '0 :
                 (RF_BYPASS && wb_en && wb_rd == f_rs1) ? wb_data : rf[f_rs1];
    assign rd2 = f_rs2 == 5'd0 ? '0 :
                 (RF_BYPASS && wb_en && wb_rd == f_rs2) ? wb_data : rf[f_rs2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc     <= '0;
            id_npc    <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            imm       <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            alu_op    <= '0;
            alu_src_a <= 1'b0;
            alu_src_b <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            wb_sel    <= '0;
            illegal   <= 1'b0;
        end else begin
            id_pc     <= PC;
            id_npc    <= NPC;
            rs1_data  <= rd1;
            rs2_data  <= rd2;
            imm       <= c_imm;
            rs1       <= f_rs1;
            rs2       <= f_rs2;
            rd        <= IR[11:7];
            alu_op    <= bubble ? 4'd0 : c_alu_op;
            alu_src_a <= !bubble && c_src_a;
            alu_src_b <= !bubble && c_src_b;
            mem_read  <= !bubble && c_mr;
            mem_write <= !bubble && c_mw;
            reg_write <= !bubble && c_rw;
            branch    <= !bubble && c_br;
            jump      <= !bubble && c_jmp;
            wb_sel    <= bubble ? 2'b00 : c_wb_sel;
            illegal   <= !bubble && c_ill;
        end
    end
endmodule
